// File: rtl/rll_key_pkg.sv
// Shared types and helpers for the RLL key loader: FSM state encoding,
// default key width and the timeout counter sizing function.
package rll_key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        DONE,
        ERR
    } rll_key_state_t;

    localparam int unsigned KEY_W_DFLT = 32;

    function automatic int unsigned tmo_cnt_width(input int unsigned timeout_cyc);
        return $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/rll_key_shift.sv
// Serial-to-parallel shadow register for the unlock key: LSB-first bit capture,
// beat counting and a running XOR over every accepted beat (key plus parity).
module rll_key_shift
    import rll_key_pkg::*;
#(
    parameter int unsigned KEY_WIDTH = KEY_W_DFLT,
    parameter int unsigned PARITY_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 shift_en,
    input  logic                 din,
    output logic [KEY_WIDTH-1:0] shadow,
    output logic                 last_beat,
    output logic                 par_ok
);

    localparam int unsigned NBEATS = KEY_WIDTH + ((PARITY_EN != 0) ? 1 : 0);
    localparam int unsigned CW     = $clog2(NBEATS + 1);

    logic [CW-1:0]        r_cnt;
    logic [KEY_WIDTH-1:0] r_shadow;
    logic                 r_par;

    // The parity beat lands at index KEY_WIDTH and is never stored, only folded into r_par.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt    <= '0;
            r_shadow <= '0;
            r_par    <= 1'b0;
        end else if (shift_en) begin
            for (int unsigned i = 0; i < KEY_WIDTH; i++) begin
                if (r_cnt == CW'(i)) begin
                    r_shadow[i] <= din;
                end
            end
            r_cnt <= r_cnt + 1'b1;
            r_par <= r_par ^ din;
        end
    end

    assign shadow    = r_shadow;
    assign last_beat = (r_cnt == CW'(NBEATS - 1));
    assign par_ok    = (PARITY_EN != 0) ? ~r_par : 1'b1;

endmodule

// File: rtl/rll_key_loader.sv
// Loads the RLL unlock key from the serial key store, verifies its parity and
// drives it to the locked core; the bus stays zero until a good key is frozen.
module rll_key_loader
    import rll_key_pkg::*;
#(
    parameter int unsigned KEY_WIDTH   = KEY_W_DFLT,
    parameter int unsigned PARITY_EN   = 1,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sdata_in,
    input  logic                 sdata_valid,
    output logic                 sdata_ready,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_valid,
    output logic                 key_err,
    output logic                 busy
);

    localparam int unsigned TW = tmo_cnt_width(TIMEOUT_CYC);

    rll_key_state_t       r_state;
    rll_key_state_t       w_next;
    logic [TW-1:0]        r_tmo;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_valid;
    logic                 r_err;
    logic [KEY_WIDTH-1:0] r_key;

    logic                 w_accept;
    logic                 w_clr;
    logic                 w_last;
    logic                 w_par_ok;
    logic [KEY_WIDTH-1:0] w_shadow;
    logic                 w_ready_nxt;
    logic                 w_busy_nxt;
    logic                 w_valid_nxt;
    logic                 w_err_nxt;
    logic                 w_load_key;

    assign w_accept = sdata_valid && r_ready;
    assign w_clr    = (w_next == LOAD) && (r_state != LOAD);

    rll_key_shift #(
        .KEY_WIDTH (KEY_WIDTH),
        .PARITY_EN (PARITY_EN)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_clr),
        .shift_en  (w_accept),
        .din       (sdata_in),
        .shadow    (w_shadow),
        .last_beat (w_last),
        .par_ok    (w_par_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_tmo   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_key   <= '0;
        end else begin
            r_state <= w_next;
            r_tmo   <= (r_state != LOAD || w_accept) ? '0 : r_tmo + 1'b1;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
            if (w_load_key) begin
                r_key <= w_shadow;
            end
        end
    end

    // An accepted beat takes priority over an expiring timeout in the same cycle.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = LOAD;
            LOAD: begin
                if (w_accept && w_last) begin
                    w_next = CHECK;
                end else if (!w_accept && r_tmo == TW'(TIMEOUT_CYC - 1)) begin
                    w_next = ERR;
                end
            end
            CHECK:   w_next = w_par_ok ? DONE : ERR;
            DONE:    w_next = DONE;
            ERR:     if (start) w_next = LOAD;
            default: w_next = IDLE;
        endcase
    end

    // Registered outputs are computed from the upcoming state.
    always_comb begin
        w_ready_nxt = (w_next == LOAD);
        w_busy_nxt  = (w_next == LOAD) || (w_next == CHECK);
        w_valid_nxt = (w_next == DONE);
        w_err_nxt   = (w_next == ERR);
        w_load_key  = (r_state == CHECK) && w_par_ok;
    end

    assign sdata_ready = r_ready;
    assign busy        = r_busy;
    assign key_valid   = r_valid;
    assign key_err     = r_err;
    assign key_out     = r_key;

endmodule

// File: tb/tb_rll_key_loader.sv
// Self-checking bench for rll_key_loader: scenario tasks with randomized keys and
// gaps, expectations derived from a behavioural model of the key-load rules.
module tb_rll_key_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sdata_in = 1'b0;
    logic        sdata_valid = 1'b0;

    logic        sdata_ready;
    logic [31:0] key_out;
    logic        key_valid;
    logic        key_err;
    logic        busy;

    logic        np_ready;
    logic [31:0] np_key_out;
    logic        np_key_valid;
    logic        np_key_err;
    logic        np_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rll_key_loader #(
        .KEY_WIDTH   (32),
        .PARITY_EN   (1),
        .TIMEOUT_CYC (1024)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sdata_in    (sdata_in),
        .sdata_valid (sdata_valid),
        .sdata_ready (sdata_ready),
        .key_out     (key_out),
        .key_valid   (key_valid),
        .key_err     (key_err),
        .busy        (busy)
    );

    rll_key_loader #(
        .KEY_WIDTH   (32),
        .PARITY_EN   (0),
        .TIMEOUT_CYC (1024)
    ) u_dut_np (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sdata_in    (sdata_in),
        .sdata_valid (sdata_valid),
        .sdata_ready (np_ready),
        .key_out     (np_key_out),
        .key_valid   (np_key_valid),
        .key_err     (np_key_err),
        .busy        (np_busy)
    );

    // Beat stream model: key bits LSB first, then the bit that makes the total XOR even.
    function automatic logic [32:0] mk_beats(input logic [31:0] key, input bit corrupt);
        logic par;
        par = (^key) ^ corrupt;
        return {par, key};
    endfunction

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; sdata_valid = 1'b0; sdata_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive_beats(input logic [32:0] beats, input int n, input int maxgap,
                               input int force_idx, input int force_gap,
                               output int nacc, output int nacc_np);
        int gap;
        nacc = 0;
        nacc_np = 0;
        for (int k = 0; k < n; k++) begin
            if (k == force_idx) gap = force_gap;
            else if (maxgap > 0) gap = int'($urandom_range(0, maxgap));
            else gap = 0;
            repeat (gap) @(negedge clk);
            if (sdata_ready) nacc++;
            if (np_ready) nacc_np++;
            sdata_valid = 1'b1;
            sdata_in = beats[k];
            @(negedge clk);
            sdata_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (key_out !== 32'h0) begin errors++; $display("FAIL reset_key_out got %h want 0", key_out); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid got %b want 0", key_valid); end
        checks++; if (key_err !== 1'b0) begin errors++; $display("FAIL reset_key_err got %b want 0", key_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (sdata_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", sdata_ready); end
    endtask

    task automatic test_good_key();
        logic [31:0] key;
        int na, nn;
        key = 32'hA5C3_0F96;
        do_reset();
        pulse_start();
        checks++; if (sdata_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL good_load_entry ready=%b busy=%b want 1 1", sdata_ready, busy); end
        drive_beats(mk_beats(key, 1'b0), 33, 0, -1, 0, na, nn);
        checks++; if (na !== 33) begin errors++; $display("FAIL good_accepted got %0d want 33", na); end
        checks++; if (key_valid !== 1'b0 || sdata_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL good_check_cycle valid=%b ready=%b busy=%b want 0 0 1", key_valid, sdata_ready, busy); end
        checks++; if (key_out !== 32'h0) begin errors++; $display("FAIL good_no_partial got %h want 0", key_out); end
        @(negedge clk);
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL good_valid got %b want 1", key_valid); end
        checks++; if (key_out !== key) begin errors++; $display("FAIL good_key_out got %h want %h", key_out, key); end
        checks++; if (key_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL good_err_busy got %b %b want 0 0", key_err, busy); end
    endtask

    task automatic test_bad_parity();
        logic [31:0] key;
        int na, nn;
        key = 32'hA5C3_0F96;
        do_reset();
        pulse_start();
        drive_beats(mk_beats(key, 1'b1), 33, 0, -1, 0, na, nn);
        @(negedge clk);
        checks++; if (key_err !== 1'b1) begin errors++; $display("FAIL badpar_err got %b want 1", key_err); end
        checks++; if (key_out !== 32'h0 || key_valid !== 1'b0) begin
            errors++; $display("FAIL badpar_out key=%h valid=%b want 0 0", key_out, key_valid); end
        checks++; if (sdata_ready !== 1'b0) begin errors++; $display("FAIL badpar_ready got %b want 0", sdata_ready); end
        pulse_start();
        checks++; if (key_err !== 1'b0 || busy !== 1'b1 || sdata_ready !== 1'b1) begin
            errors++; $display("FAIL badpar_restart err=%b busy=%b ready=%b want 0 1 1", key_err, busy, sdata_ready); end
        drive_beats(mk_beats(key, 1'b0), 33, 0, -1, 0, na, nn);
        @(negedge clk);
        checks++; if (key_valid !== 1'b1 || key_out !== key) begin
            errors++; $display("FAIL badpar_reload valid=%b key=%h want 1 %h", key_valid, key_out, key); end
    endtask

    task automatic test_gaps();
        logic [31:0] key;
        int na, nn;
        key = $urandom;
        do_reset();
        pulse_start();
        drive_beats(mk_beats(key, 1'b0), 33, 150, 5, 1000, na, nn);
        checks++; if (na !== 33) begin errors++; $display("FAIL gaps_accepted got %0d want 33", na); end
        @(negedge clk);
        checks++; if (key_valid !== 1'b1 || key_out !== key || key_err !== 1'b0) begin
            errors++; $display("FAIL gaps_result valid=%b key=%h err=%b want 1 %h 0", key_valid, key_out, key_err, key); end

        do_reset();
        pulse_start();
        drive_beats(mk_beats(key, 1'b0), 11, 0, -1, 0, na, nn);
        repeat (1023) @(negedge clk);
        checks++; if (key_err !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL timeout_early err=%b busy=%b want 0 1", key_err, busy); end
        @(negedge clk);
        checks++; if (key_err !== 1'b1 || busy !== 1'b0 || sdata_ready !== 1'b0) begin
            errors++; $display("FAIL timeout_err err=%b busy=%b ready=%b want 1 0 0", key_err, busy, sdata_ready); end
        checks++; if (key_out !== 32'h0 || key_valid !== 1'b0) begin
            errors++; $display("FAIL timeout_key key=%h valid=%b want 0 0", key_out, key_valid); end
    endtask

    task automatic test_write_once();
        logic [31:0] key;
        int na, nn;
        key = $urandom;
        do_reset();
        pulse_start();
        drive_beats(mk_beats(key, 1'b0), 33, 0, -1, 0, na, nn);
        @(negedge clk);
        pulse_start();
        checks++; if (busy !== 1'b0 || sdata_ready !== 1'b0) begin
            errors++; $display("FAIL wonce_start busy=%b ready=%b want 0 0", busy, sdata_ready); end
        drive_beats(33'h1_FFFF_FFFF, 33, 0, -1, 0, na, nn);
        checks++; if (na !== 0) begin errors++; $display("FAIL wonce_ready_beats got %0d want 0", na); end
        repeat (2) @(negedge clk);
        checks++; if (key_out !== key || key_valid !== 1'b1) begin
            errors++; $display("FAIL wonce_key key=%h valid=%b want %h 1", key_out, key_valid, key); end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] key;
        int na, nn;
        key = $urandom;
        do_reset();
        pulse_start();
        drive_beats(mk_beats(key, 1'b0), 21, 0, -1, 0, na, nn);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (key_out !== 32'h0 || key_valid !== 1'b0 || key_err !== 1'b0 || busy !== 1'b0 || sdata_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs key=%h v=%b e=%b b=%b r=%b want all 0", key_out, key_valid, key_err, busy, sdata_ready); end
        key = ~key;
        pulse_start();
        drive_beats(mk_beats(key, 1'b0), 33, 0, -1, 0, na, nn);
        @(negedge clk);
        checks++; if (key_valid !== 1'b1 || key_out !== key) begin
            errors++; $display("FAIL midrst_reload valid=%b key=%h want 1 %h", key_valid, key_out, key); end
    endtask

    task automatic test_no_parity();
        logic [31:0] key;
        int na, nn;
        key = 32'h0000_0001;
        do_reset();
        pulse_start();
        drive_beats({1'b0, key}, 32, 0, -1, 0, na, nn);
        checks++; if (nn !== 32) begin errors++; $display("FAIL nopar_accepted got %0d want 32", nn); end
        checks++; if (np_ready !== 1'b0 || np_busy !== 1'b1 || np_key_valid !== 1'b0) begin
            errors++; $display("FAIL nopar_check ready=%b busy=%b valid=%b want 0 1 0", np_ready, np_busy, np_key_valid); end
        checks++; if (sdata_ready !== 1'b1) begin errors++; $display("FAIL nopar_main_waits got %b want 1", sdata_ready); end
        @(negedge clk);
        checks++; if (np_key_valid !== 1'b1 || np_key_out !== key || np_key_err !== 1'b0) begin
            errors++; $display("FAIL nopar_done valid=%b key=%h err=%b want 1 %h 0", np_key_valid, np_key_out, np_key_err, key); end
    endtask

    initial begin
        test_reset();
        test_good_key();
        test_bad_parity();
        test_gaps();
        test_write_once();
        test_reset_mid_load();
        test_no_parity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
